// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite encodings, slave state enum and byte-lane helper
// Purpose: common types for ahbl_slave_mem and its storage sub-module.
// Contents: htrans_e (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, state_e,
//           byte_en() which maps HSIZE + HADDR[1:0] to little-endian lanes.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Lane mask for an aligned access; oversize values return no lanes
  // (they are rejected as errors before reaching the RAM anyway).
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lane;
      HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahbl_slave_mem_ram.sv
// rtl/ahbl_slave_mem_ram.sv - single-port word RAM with byte-lane write enables
// Purpose: storage array for ahbl_slave_mem. Write is synchronous, read is
//          combinational so a just-committed write is visible next cycle.
// Ports: i_clk clock; i_we write strobe; i_be[3:0] byte lanes; i_addr word
//        index; i_wdata write word; o_rdata word at i_addr.
module ahbl_slave_mem_ram #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahbl_slave_mem.sv
// rtl/ahbl_slave_mem.sv - AHB-Lite memory slave with wait states and ERROR responses
// Purpose: MEM_WORDS x 32-bit memory at BASE_ADDR, WAIT_STATES stall cycles per
//          OKAY transfer, two-cycle ERROR for bad size/alignment/range.
// Ports: HCLK, HRESET (sync, active-high); AHB-Lite address/control inputs
//        HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST/HPROT/HMASTLOCK (ignored),
//        HWDATA, HREADY; outputs HRDATA, HREADYOUT, HRESP.
module ahbl_slave_mem
  import ahbl_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] LP_WS_M1 = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e        r_state;
  logic          r_hreadyout;
  logic          r_hresp;
  logic [3:0]    r_wait_cnt;
  logic          r_dp_valid;   // an OKAY transfer is in its data phase
  logic          r_dp_write;
  logic [3:0]    r_dp_be;
  logic [AW-1:0] r_dp_idx;

  logic          w_accept;
  logic          w_err;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic          w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_accept = HSEL && HTRANS[1] && HREADY;
  assign w_offset = HADDR - BASE_ADDR;
  assign w_idx    = w_offset[AW+1:2];
  assign w_be     = byte_en(HSIZE, HADDR[1:0]);

  // Addresses below BASE_ADDR wrap to a huge offset, so the range test below
  // also rejects them; nothing ever folds back into the array.
  assign w_err = (HSIZE > HSIZE_WORD)
              || ((HSIZE == HSIZE_HALF) && HADDR[0])
              || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
              || ((w_offset >> (AW + 2)) != 32'd0);

  // Commit lands on the edge that ends the data phase; because the RAM read
  // is combinational this write-through acts as the bypass that hands the
  // merged word to a read issued right behind the write.
  assign w_we = r_dp_valid && r_dp_write && r_hreadyout;

  assign w_unused = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK, w_offset[1:0]};

  ahbl_slave_mem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_be    (r_dp_be),
    .i_addr  (r_dp_idx),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  // Only IDLE and ERR2 drive HREADYOUT high, so only they sample the address
  // phase; stalled cycles never look at HTRANS.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_wait_cnt  <= 4'd0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_be     <= 4'd0;
      r_dp_idx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_dp_valid <= w_accept && !w_err;
          if (w_accept) begin
            r_dp_write <= HWRITE;
            r_dp_be    <= w_be;
            r_dp_idx   <= w_idx;
          end
          if (w_accept && w_err) begin
            r_state     <= ST_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else if (w_accept && (WAIT_STATES != 0)) begin
            r_state     <= ST_WAIT;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
            r_wait_cnt  <= LP_WS_M1;
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = (r_dp_valid && !r_dp_write && r_hreadyout) ? w_rdata : 32'd0;

endmodule

// File: doc/ahbl_slave_mem.md
AHBL_SLAVE_MEM -- requirements
Module: ahbl_slave_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit words of internal storage (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 0, giving the number of HREADYOUT-low cycles inserted per OKAY data phase (range 0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, giving the byte address of word 0.
REQ-004 HCLK  in  1  sole clock; all state changes on the rising edge.
REQ-005 HRESET  in  1  reset, synchronous and active-high.
REQ-006 HSEL  in  1  slave select.
REQ-007 HADDR  in  32  byte address.
REQ-008 HTRANS  in  2  transfer type: IDLE, BUSY, NONSEQ or SEQ.
REQ-009 HWRITE  in  1  1 = write.
REQ-010 HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-011 HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted and ignored.
REQ-012 HWDATA  in  32  write data, valid in the data phase.
REQ-013 HREADY  in  1  bus-wide ready; qualifies the address phase.
REQ-014 HRDATA  out  32  read data.
REQ-015 HREADYOUT  out  1  this slave's ready.
REQ-016 HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-017 SHALL accept an address phase only when HSEL=1, HTRANS[1]=1 and HREADY=1 on a clock edge.
- At that edge it captures address, write flag and size.
- It also determines the next state.
REQ-018 SHALL give a zero-wait OKAY response to IDLE or BUSY transfers, and whenever no transfer is selected.
REQ-019 SHALL classify an accepted transfer as an error if any of the following holds:
- HSIZE > 2;
- the address is misaligned for its size;
- the word index (HADDR-BASE_ADDR)>>2 is >= MEM_WORDS.
REQ-020 The state machine SHALL have four states: IDLE, WAIT, ERR1, ERR2.
- IDLE -> WAIT: OKAY transfer accepted and WAIT_STATES > 0.
- IDLE -> IDLE: OKAY transfer accepted and WAIT_STATES = 0, or no transfer accepted.
- IDLE -> ERR1: error transfer accepted.
- WAIT -> IDLE: after WAIT_STATES cycles.
- ERR1 -> ERR2: unconditional.
- ERR2 -> IDLE, or to ERR1/WAIT if a new transfer is accepted at that edge.
REQ-021 In WAIT, outputs SHALL be HREADYOUT=0, HRESP=0, and a down-counter loaded with WAIT_STATES-1 SHALL control the exit.
REQ-022 In ERR1, outputs SHALL be HREADYOUT=0, HRESP=1. In ERR2, outputs SHALL be HREADYOUT=1, HRESP=1.
REQ-023 An errored transfer SHALL never modify memory.
REQ-024 Writes SHALL commit HWDATA at the edge ending the data phase (HREADYOUT=1, OKAY), using byte lanes from HSIZE and HADDR[1:0] (little-endian).
REQ-025 Read data SHALL be valid on HRDATA during the final data-phase cycle (HREADYOUT=1) as the full 32-bit word. HRDATA SHALL be 0 in all other cycles, including ERROR responses.
REQ-026 A read immediately following a write to the same word SHALL return the merged new data.
- The merge SHALL use a bypass path.
- This holds at any WAIT_STATES value.
REQ-027 Back-to-back pipelined transfers SHALL sustain one transfer per cycle when WAIT_STATES=0.
REQ-028 An address phase presented while HREADYOUT=0 SHALL be sampled only when HREADY rises. The state machine SHALL not depend on HTRANS in stalled cycles.
REQ-029 Word index arithmetic SHALL use log2(MEM_WORDS) bits. Out-of-range addresses SHALL error, never wrap.

Reset
REQ-030 On HRESET=1 at an edge, the block SHALL enter IDLE with HREADYOUT=1, HRESP=0, HRDATA=0.
- The wait counter SHALL clear.
- Any pending captured transfer SHALL be discarded, including an uncommitted write.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 HRESET asserted mid-WAIT or mid-ERR1 SHALL abort the response; outputs SHALL hold reset values on the next cycle.

Structure
REQ-033 A shared package ahbl_pkg SHALL hold:
- the HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
- the HSIZE encodings;
- the state enum.
REQ-034 The storage array with byte-lane write enables SHALL be the sub-module ahbl_slave_mem_ram.
- Single port.
- Synchronous write, combinational read.

Verification
REQ-035 WAIT_STATES=0: write word 32'hDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase returns 32'hDEADBEEF, HREADYOUT high throughout.
REQ-036 Byte write 8'hA5 to 0x13 over word 0, then word read 0x10 -> HRDATA=32'hA5000000.
REQ-037 WAIT_STATES=3: word read -> exactly 3 cycles HREADYOUT=0, then data with HRESP=0.
REQ-038 Read at BASE_ADDR+4*MEM_WORDS -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), HRDATA=0. Halfword write to 0x01 -> same two-cycle ERROR, memory unchanged.
REQ-039 HTRANS=BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0, no memory access.
REQ-040 HRESET pulsed during the WAIT of a write -> next cycle HREADYOUT=1, HRESP=0; a later read of that address returns the old data.
